bluejay_rx: RTL and testbench

- Receive-side end of the Bluejay SLM data interface: consumes the sync/valid/data/update stream that the line transmitter drives toward the display.
- Deframes lines and frames, undoes the optional DC-balance inversion, and re-emits words with line and frame markers.
- Flags every framing violation and keeps per-line XOR checksums.
- Used as the display-side model in system benches and as an on-chip loopback checker.

---
 rtl/bluejay_pkg.sv | 24 ++
 rtl/bluejay_line_ctr.sv | 51 +++++
 rtl/bluejay_rx.sv | 165 ++++++++++++++++
 tb/tb_bluejay_rx.sv | 159 +++++++++++++++
 4 files changed

// File: rtl/bluejay_pkg.sv
// bluejay_pkg: shared definitions for the Bluejay SLM line transmitter and receiver.
//   Holds interface geometry defaults, the receiver deframer state encoding
//   and the bit positions of the receiver error flags.
package bluejay_pkg;

    localparam int DEF_DATA_W          = 32;
    localparam int DEF_WORDS_PER_LINE  = 40;
    localparam int DEF_LINES_PER_FRAME = 720;
    localparam int DEF_CNT_W           = 16;

    localparam int ERR_W              = 4;
    localparam int ERR_SYNC_IN_LINE   = 0;
    localparam int ERR_STRAY_VALID    = 1;
    localparam int ERR_EARLY_UPDATE   = 2;
    localparam int ERR_EXTRA_LINE     = 3;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT_DATA,
        ST_LINE,
        ST_WAIT_UPDATE
    } state_e;

endpackage

// File: rtl/bluejay_line_ctr.sv
// bluejay_line_ctr: word-within-line and line-within-frame counters with terminal flags.
//   clk_i, reset_i (async, active-low)
//   word_clr_i / word_inc_i : clear / advance the word counter (clear wins)
//   line_clr_i / line_inc_i : clear / advance the line counter (clear wins)
//   line_cnt_o              : current line index
//   word_last_o             : word counter sits on the last word of a line
//   line_last_o             : line counter sits on the last line of a frame
//   line_zero_o             : line counter is zero (next line is line 0)
module bluejay_line_ctr
    import bluejay_pkg::*;
#(
    parameter int WORDS_PER_LINE  = DEF_WORDS_PER_LINE,
    parameter int LINES_PER_FRAME = DEF_LINES_PER_FRAME,
    parameter int CNT_W           = DEF_CNT_W
) (
    input  logic             clk_i,
    input  logic             reset_i,
    input  logic             word_clr_i,
    input  logic             word_inc_i,
    input  logic             line_clr_i,
    input  logic             line_inc_i,
    output logic [CNT_W-1:0] line_cnt_o,
    output logic             word_last_o,
    output logic             line_last_o,
    output logic             line_zero_o
);

    logic [CNT_W-1:0] word_q, word_d;
    logic [CNT_W-1:0] line_q, line_d;

    always_comb begin
        word_d = word_clr_i ? '0 : word_q + CNT_W'(word_inc_i);
        line_d = line_clr_i ? '0 : line_q + CNT_W'(line_inc_i);
    end

    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            word_q <= '0;
            line_q <= '0;
        end else begin
            word_q <= word_d;
            line_q <= line_d;
        end
    end

    assign line_cnt_o  = line_q;
    assign word_last_o = word_q == CNT_W'(WORDS_PER_LINE - 1);
    assign line_last_o = line_q == CNT_W'(LINES_PER_FRAME - 1);
    assign line_zero_o = line_q == '0;

endmodule

// File: rtl/bluejay_rx.sv
// bluejay_rx: Bluejay SLM receive-side deframer with DC-balance undo, markers and checksums.
//   clk_i, reset_i (async, active-low)
//   sync_i / valid_i / data_i / update_i / invert_i : incoming line stream
//   data_o / valid_o / sol_o / eol_o / line_o       : de-inverted words, one cycle after valid_i
//   line_xor_o / line_done_o                         : XOR of the last completed line
//   frame_done_o                                     : pulse on a legal frame commit
//   err_o / err_clr_i                                : sticky framing errors and their clear
module bluejay_rx
    import bluejay_pkg::*;
#(
    parameter int DATA_W          = DEF_DATA_W,
    parameter int WORDS_PER_LINE  = DEF_WORDS_PER_LINE,
    parameter int LINES_PER_FRAME = DEF_LINES_PER_FRAME,
    parameter int CNT_W           = DEF_CNT_W
) (
    input  logic              clk_i,
    input  logic              reset_i,
    input  logic              sync_i,
    input  logic              valid_i,
    input  logic [DATA_W-1:0] data_i,
    input  logic              update_i,
    input  logic              invert_i,
    output logic [DATA_W-1:0] data_o,
    output logic              valid_o,
    output logic              sol_o,
    output logic              eol_o,
    output logic [CNT_W-1:0]  line_o,
    output logic [DATA_W-1:0] line_xor_o,
    output logic              line_done_o,
    output logic              frame_done_o,
    output logic [ERR_W-1:0]  err_o,
    input  logic              err_clr_i
);

    state_e state_q, state_d;

    logic              emit, sol, inv_load, frame_done;
    logic              word_clr, word_inc, line_clr, line_inc;
    logic [ERR_W-1:0]  err_set;
    logic [CNT_W-1:0]  line_cnt;
    logic              word_last, line_last, line_zero;
    logic              inv_q;
    logic [DATA_W-1:0] word, acc_q;

    bluejay_line_ctr #(
        .WORDS_PER_LINE (WORDS_PER_LINE),
        .LINES_PER_FRAME(LINES_PER_FRAME),
        .CNT_W          (CNT_W)
    ) u_ctr (
        .clk_i      (clk_i),
        .reset_i    (reset_i),
        .word_clr_i (word_clr),
        .word_inc_i (word_inc),
        .line_clr_i (line_clr),
        .line_inc_i (line_inc),
        .line_cnt_o (line_cnt),
        .word_last_o(word_last),
        .line_last_o(line_last),
        .line_zero_o(line_zero)
    );

    assign word = data_i ^ {DATA_W{inv_q}};

    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) state_q <= ST_IDLE;
        else          state_q <= state_d;
    end

    // Priority is sync_i > update_i > valid_i; a valid_i shadowed by either strobe is dropped and flagged.
    always_comb begin
        state_d    = state_q;
        emit       = 1'b0;
        sol        = 1'b0;
        inv_load   = 1'b0;
        frame_done = 1'b0;
        word_clr   = 1'b0;
        word_inc   = 1'b0;
        line_clr   = 1'b0;
        line_inc   = 1'b0;
        err_set    = '0;
        err_set[ERR_STRAY_VALID] = valid_i && (sync_i || update_i);
        case (state_q)
            ST_IDLE: begin
                if (sync_i) begin
                    state_d  = ST_WAIT_DATA;
                    word_clr = 1'b1;
                    inv_load = line_zero;
                end else if (update_i) begin
                    err_set[ERR_EARLY_UPDATE] = 1'b1;
                    line_clr = 1'b1;
                end else if (valid_i) begin
                    err_set[ERR_STRAY_VALID] = 1'b1;
                end
            end
            ST_WAIT_DATA, ST_LINE: begin
                if (sync_i) begin
                    err_set[ERR_SYNC_IN_LINE] = state_q == ST_LINE;
                    state_d  = ST_WAIT_DATA;
                    word_clr = 1'b1;
                end else if (update_i) begin
                    err_set[ERR_EARLY_UPDATE] = 1'b1;
                    state_d  = ST_IDLE;
                    word_clr = 1'b1;
                    line_clr = 1'b1;
                end else if (valid_i) begin
                    emit = 1'b1;
                    sol  = state_q == ST_WAIT_DATA;
                end
            end
            ST_WAIT_UPDATE: begin
                // A sync here closes the old frame without a commit and opens line 0 of the next.
                if (sync_i) begin
                    err_set[ERR_EXTRA_LINE] = 1'b1;
                    state_d  = ST_WAIT_DATA;
                    word_clr = 1'b1;
                    line_clr = 1'b1;
                    inv_load = 1'b1;
                end else if (update_i) begin
                    frame_done = 1'b1;
                    state_d    = ST_IDLE;
                    line_clr   = 1'b1;
                end else if (valid_i) begin
                    err_set[ERR_STRAY_VALID] = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        if (emit) begin
            word_clr = word_last;
            word_inc = !word_last;
            line_inc = word_last;
            state_d  = !word_last ? ST_LINE : line_last ? ST_WAIT_UPDATE : ST_IDLE;
        end
    end

    // line_done_o trails eol_o by one cycle, so the accumulator already holds the last word.
    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            data_o       <= '0;
            valid_o      <= 1'b0;
            sol_o        <= 1'b0;
            eol_o        <= 1'b0;
            line_o       <= '0;
            line_xor_o   <= '0;
            line_done_o  <= 1'b0;
            frame_done_o <= 1'b0;
            err_o        <= '0;
            inv_q        <= 1'b0;
            acc_q        <= '0;
        end else begin
            valid_o      <= emit;
            sol_o        <= sol;
            eol_o        <= emit && word_last;
            line_done_o  <= eol_o;
            frame_done_o <= frame_done;
            err_o        <= (err_o & {ERR_W{!err_clr_i}}) | err_set;
            if (emit) data_o <= word;
            if (emit) acc_q <= sol ? word : acc_q ^ word;
            if (sol) line_o <= line_cnt;
            if (eol_o) line_xor_o <= acc_q;
            if (inv_load) inv_q <= invert_i;
        end
    end

endmodule

// File: tb/tb_bluejay_rx.sv
// tb_bluejay_rx: directed self-checking bench for bluejay_rx with a 4-word, 2-line frame.
module tb_bluejay_rx;

    logic        clk = 1'b0;
    logic        reset_i = 1'b0;
    logic        sync_i = 1'b0, valid_i = 1'b0, update_i = 1'b0, invert_i = 1'b0, err_clr_i = 1'b0;
    logic [31:0] data_i = '0;
    logic [31:0] data_o, line_xor_o;
    logic        valid_o, sol_o, eol_o, line_done_o, frame_done_o;
    logic [15:0] line_o;
    logic [3:0]  err_o;
    int          tests = 0;
    int          fails = 0;

    bluejay_rx #(
        .DATA_W(32), .WORDS_PER_LINE(4), .LINES_PER_FRAME(2), .CNT_W(16)
    ) dut (
        .clk_i(clk), .reset_i(reset_i), .sync_i(sync_i), .valid_i(valid_i), .data_i(data_i),
        .update_i(update_i), .invert_i(invert_i), .data_o(data_o), .valid_o(valid_o),
        .sol_o(sol_o), .eol_o(eol_o), .line_o(line_o), .line_xor_o(line_xor_o),
        .line_done_o(line_done_o), .frame_done_o(frame_done_o), .err_o(err_o), .err_clr_i(err_clr_i)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [95:0] obs, input logic [95:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic s, input logic v, input logic u, input logic [31:0] d);
        sync_i   = s;
        valid_i  = v;
        update_i = u;
        data_i   = d;
        @(posedge clk);
        #1;
    endtask

    task automatic send_line(input logic do_sync, input logic inv, input logic [31:0] first,
                             input logic [15:0] exp_line, input logic [31:0] exp_xor);
        logic [31:0] w;
        if (do_sync) begin
            drive(1, 0, 0, 0);
            chk("sync_no_valid", valid_o, 0);
            chk("sync_no_frame_done", frame_done_o, 0);
        end
        for (int k = 0; k < 4; k++) begin
            w = first + k;
            drive(0, 1, 0, inv ? ~w : w);
            chk("valid_o", valid_o, 1);
            chk("data_o", data_o, w);
            chk("sol_o", sol_o, k == 0);
            chk("eol_o", eol_o, k == 3);
            chk("line_o", line_o, exp_line);
        end
        drive(0, 0, 0, 0);
        chk("line_done_o", line_done_o, 1);
        chk("line_xor_o", line_xor_o, exp_xor);
        chk("idle_valid_o", valid_o, 0);
    endtask

    task automatic clear_err();
        err_clr_i = 1'b1;
        drive(0, 0, 0, 0);
        err_clr_i = 1'b0;
        chk("err_clr", err_o, 0);
    endtask

    initial begin
        #12;
        chk("reset_outputs", {data_o, valid_o, sol_o, eol_o, line_o, line_xor_o, line_done_o, frame_done_o, err_o}, 0);
        reset_i = 1'b1;

        // nominal frame
        send_line(1, 0, 1, 0, 32'h4);
        send_line(1, 0, 5, 1, 32'hC);
        drive(0, 0, 1, 0);
        chk("nom_frame_done", frame_done_o, 1);
        chk("nom_err", err_o, 0);
        drive(0, 0, 0, 0);
        chk("frame_done_pulse", frame_done_o, 0);

        // inverted frame, invert_i toggled before line 1 must be ignored
        invert_i = 1'b1;
        send_line(1, 1, 1, 0, 32'h4);
        invert_i = 1'b0;
        send_line(1, 1, 5, 1, 32'hC);
        drive(0, 0, 1, 0);
        chk("inv_frame_done", frame_done_o, 1);
        chk("inv_err", err_o, 0);

        // sync after 2 words of line 0
        drive(1, 0, 0, 0);
        drive(0, 1, 0, 1);
        drive(0, 1, 0, 2);
        drive(1, 0, 0, 0);
        chk("midsync_err", err_o, 4'b0001);
        chk("midsync_no_done", line_done_o, 0);
        chk("midsync_line_o", line_o, 0);
        send_line(0, 0, 5, 0, 32'hC);
        clear_err();

        // update after line 0 only
        drive(0, 0, 1, 0);
        chk("early_upd_err", err_o, 4'b0100);
        chk("early_upd_no_frame", frame_done_o, 0);
        send_line(1, 0, 1, 0, 32'h4);
        send_line(1, 0, 5, 1, 32'hC);
        drive(0, 0, 1, 0);
        chk("early_recover_frame_done", frame_done_o, 1);
        clear_err();

        // stray valid in IDLE
        drive(0, 1, 0, 32'h99);
        chk("stray_no_valid", valid_o, 0);
        chk("stray_err", err_o, 4'b0010);
        clear_err();

        // extra sync in WAIT_UPDATE starts a new frame at line 0
        send_line(1, 0, 1, 0, 32'h4);
        send_line(1, 0, 5, 1, 32'hC);
        send_line(1, 0, 1, 0, 32'h4);
        chk("extra_err", err_o, 4'b1000);
        send_line(1, 0, 5, 1, 32'hC);
        drive(0, 0, 1, 0);
        chk("extra_frame_done", frame_done_o, 1);
        clear_err();

        // asynchronous reset mid-line
        drive(1, 0, 0, 0);
        drive(0, 1, 0, 1);
        drive(0, 1, 0, 2);
        #3;
        reset_i = 1'b0;
        #1;
        chk("async_reset_outputs", {data_o, valid_o, sol_o, eol_o, line_o, line_xor_o, line_done_o, frame_done_o, err_o}, 0);
        #2;
        reset_i = 1'b1;
        send_line(1, 0, 1, 0, 32'h4);
        send_line(1, 0, 5, 1, 32'hC);
        drive(0, 0, 1, 0);
        chk("post_reset_frame_done", frame_done_o, 1);
        chk("post_reset_err", err_o, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
